keypad_scanner: RTL

- Drives a 4x4 active-low matrix keypad and produces the key/valid_key stream consumed by the lock controllers. It is the transmitter end of that interface.
- Scans columns one at a time and debounces both press and release.
- Emits exactly one single-cycle valid_key pulse per physical press, with a 4-bit key code.

---
 rtl/keypad_scanner_if.sv | 15 +
 rtl/keypad_scanner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
// Carries the debounced key stream from the keypad scanner to its consumers
// (the lock controllers).
//   key       : 4-bit key code of the last accepted press
//   valid_key : single-cycle strobe, key is valid in the same cycle
// Modports:
//   master : the scanner, which drives key/valid_key
//   slave  : a consumer, which only reads key/valid_key
interface keypad_scanner_if;
    logic [3:0] key;
    logic       valid_key;

    modport master (output key, output valid_key);
    modport slave  (input  key, input  valid_key);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, debounces both
// press and release, and emits exactly one valid_key strobe per physical press.
//
// Ports:
//   clk    : system clock, all logic on the rising edge
//   rstn   : synchronous active-low reset
//   row_n  : keypad rows, active low, externally pulled up
//   col_n  : registered column drive, exactly one bit low while scanning
//   kp     : keypad_scanner_if.master carrying key / valid_key (registered)
//
// Parameters:
//   SCAN_CYCLES     : cycles each column is driven before row_n is sampled (>=1)
//   DEBOUNCE_CYCLES : identical samples needed to accept a press/release (>=1)
//
// Optional feature macro: KEYPAD_ROW_SYNC_EN
//   When defined, row_n passes through a two-flop synchronizer before use and
//   each scan slot is lengthened by two cycles to cover the synchronizer delay.
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [3:0]              row_n,
    output logic [3:0]              col_n,
    keypad_scanner_if.master        kp
);

`ifdef KEYPAD_ROW_SYNC_EN
    localparam int SLOT_LEN = SCAN_CYCLES + 2;
`else
    localparam int SLOT_LEN = SCAN_CYCLES;
`endif
    localparam int SW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN + 1) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_LEN - 1);
    localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HOLD     = 2'd2,
        ST_REL_DB   = 2'd3
    } state_t;

    state_t        state_r, next_state_s;
    logic [1:0]    idx_r, next_idx_s;
    logic [SW-1:0] slot_r, next_slot_s;
    logic [CW-1:0] cnt_r, next_cnt_s;
    logic [1:0]    row_r, next_row_s;
    logic [3:0]    col_r, next_col_s;
    logic [3:0]    key_r, next_key_s;
    logic          valid_r, next_valid_s;

    logic [3:0]    rows_s;
    logic          hit_s;
    logic [1:0]    hit_row_s;
    logic          same_s;
    logic          latched_up_s;
    logic          drive_ok_s;

    // Key code for (row, column) of the keypad legend.
    function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            4'd15:   code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Active-low one-hot column drive for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Saturating debounce counter increment.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] value);
        logic [CW-1:0] res;
        if (value < DB_MAX) begin
            res = value + CNT_ONE;
        end else begin
            res = value;
        end
        return res;
    endfunction

`ifdef KEYPAD_ROW_SYNC_EN
    logic [3:0] sync1_r, sync2_r;

    // Two-flop synchronizer for the asynchronous keypad rows.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_r <= 4'b1111;
            sync2_r <= 4'b1111;
        end else begin
            sync1_r <= row_n;
            sync2_r <= sync1_r;
        end
    end

    assign rows_s = sync2_r;
`else
    assign rows_s = row_n;
`endif

    // Hit decode: exactly one low row; zero or several low rows count as no hit.
    always_comb begin
        hit_s     = 1'b0;
        hit_row_s = 2'd0;
        case (rows_s)
            4'b1110: begin hit_s = 1'b1; hit_row_s = 2'd0; end
            4'b1101: begin hit_s = 1'b1; hit_row_s = 2'd1; end
            4'b1011: begin hit_s = 1'b1; hit_row_s = 2'd2; end
            4'b0111: begin hit_s = 1'b1; hit_row_s = 2'd3; end
            default: begin hit_s = 1'b0; hit_row_s = 2'd0; end
        endcase
    end

    assign same_s       = hit_s && (hit_row_s == row_r);
    assign latched_up_s = rows_s[row_r];
    // Right after reset col_n is still all-ones; the slot only starts counting
    // once the selected column is actually being driven low.
    assign drive_ok_s   = ~col_r[idx_r];

    // Next-state and next-output logic of the scan/debounce FSM.
    always_comb begin
        next_state_s = state_r;
        next_idx_s   = idx_r;
        next_slot_s  = slot_r;
        next_cnt_s   = cnt_r;
        next_row_s   = row_r;
        next_key_s   = key_r;
        next_valid_s = 1'b0;
        case (state_r)
            ST_SCAN: begin
                if (!drive_ok_s) begin
                    next_slot_s = {SW{1'b0}};
                end else if (slot_r >= SLOT_LAST) begin
                    next_slot_s = {SW{1'b0}};
                    if (hit_s) begin
                        next_state_s = ST_PRESS_DB;
                        next_row_s   = hit_row_s;
                        next_cnt_s   = CNT_ONE;
                    end else begin
                        next_idx_s = idx_r + 2'd1;
                    end
                end else begin
                    next_slot_s = slot_r + SW'(1);
                end
            end
            ST_PRESS_DB: begin
                if (cnt_r >= DB_MAX) begin
                    next_valid_s = 1'b1;
                    next_key_s   = map_key(row_r, idx_r);
                    next_state_s = ST_HOLD;
                end else if (same_s) begin
                    next_cnt_s = sat_inc(cnt_r);
                end else begin
                    next_state_s = ST_SCAN;
                    next_idx_s   = idx_r + 2'd1;
                    next_slot_s  = {SW{1'b0}};
                    next_cnt_s   = {CW{1'b0}};
                end
            end
            ST_HOLD: begin
                // Only the latched row matters here, so a second key is ignored.
                if (latched_up_s) begin
                    next_state_s = ST_REL_DB;
                    next_cnt_s   = CNT_ONE;
                end else begin
                    next_cnt_s = cnt_r;
                end
            end
            ST_REL_DB: begin
                if (cnt_r >= DB_MAX) begin
                    next_state_s = ST_SCAN;
                    next_idx_s   = 2'd0;
                    next_slot_s  = {SW{1'b0}};
                    next_cnt_s   = {CW{1'b0}};
                end else if (latched_up_s) begin
                    next_cnt_s = sat_inc(cnt_r);
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: begin
                next_state_s = ST_SCAN;
                next_idx_s   = 2'd0;
                next_slot_s  = {SW{1'b0}};
                next_cnt_s   = {CW{1'b0}};
            end
        endcase
        next_col_s = col_drive(next_idx_s);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_SCAN;
            idx_r   <= 2'd0;
            slot_r  <= {SW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            row_r   <= 2'd0;
            col_r   <= 4'b1111;
            key_r   <= 4'h0;
            valid_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            idx_r   <= next_idx_s;
            slot_r  <= next_slot_s;
            cnt_r   <= next_cnt_s;
            row_r   <= next_row_s;
            col_r   <= next_col_s;
            key_r   <= next_key_s;
            valid_r <= next_valid_s;
        end
    end

    assign col_n        = col_r;
    assign kp.key       = key_r;
    assign kp.valid_key = valid_r;

endmodule
